// File: rtl/fire9_expand1_ofm_writer.sv
// fire9 expand1x1 OFM writer: snapshots each ofm vector and streams it into
// LANES feature-map banks, pulsing ram_feedback_o once the layer is written.
module fire9_expand1_ofm_writer #(
   parameter int DSP_NO  = 368,
   parameter int WIDTH   = 16,
   parameter int WOUT    = 8,
   parameter int LANES   = 4,
   localparam int BEATS  = DSP_NO / LANES,
   localparam int PIXELS = WOUT * WOUT,
   localparam int ADDR_W = $clog2(PIXELS * BEATS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample_i,
   input  logic [DSP_NO-1:0][WIDTH-1:0]  ofm_i,
   input  logic                          wr_ready_i,
   output logic                          wr_en_o,
   output logic [ADDR_W-1:0]             wr_addr_o,
   output logic [LANES*WIDTH-1:0]        wr_data_o,
   output logic                          busy_o,
   output logic                          ram_feedback_o,
   output logic                          overrun_o
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PIX_W  = $clog2(PIXELS + 1);
   localparam int IDX_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

   if (DSP_NO % LANES != 0) begin : g_lanes_check
      $error("DSP_NO must be a multiple of LANES");
   end

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [PIX_W-1:0]              pix_q;
   logic [BEAT_W-1:0]             beat_q;
   logic [DSP_NO-1:0][WIDTH-1:0]  snap_q;

   logic                          capture;
   logic                          accept;
   logic                          last_beat;
   logic                          frame_end;
   logic                          ovr_set;

   logic [IDX_W-1:0]              idx;
   logic [LANES-1:0][WIDTH-1:0]   lane_w;
   logic [ADDR_W-1:0]             addr_w;

   always_comb begin
      state_d   = state_q;
      wr_en_o   = 1'b0;
      busy_o    = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      last_beat = 1'b0;
      frame_end = 1'b0;
      ovr_set   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sample_i) begin
               capture = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            wr_en_o   = 1'b1;
            busy_o    = 1'b1;
            accept    = wr_ready_i;
            last_beat = accept && (beat_q == BEAT_W'(BEATS - 1));
            if (last_beat) begin
               frame_end = (pix_q == PIX_W'(PIXELS - 1));
               // the buffer frees on this edge, so a new sample can land
               if (frame_end)
                  state_d = DONE;
               else if (sample_i)
                  capture = 1'b1;
               else
                  state_d = IDLE;
            end else if (sample_i) begin
               ovr_set = 1'b1;
            end
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         pix_q          <= '0;
         beat_q         <= '0;
         ram_feedback_o <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         state_q        <= state_d;
         ram_feedback_o <= frame_end;
         if (ovr_set)
            overrun_o <= 1'b1;
         if (last_beat || capture)
            beat_q <= '0;
         else if (accept)
            beat_q <= beat_q + BEAT_W'(1);
         if (last_beat)
            pix_q <= pix_q + PIX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (capture)
         snap_q <= ofm_i;
   end

   assign idx    = IDX_W'(beat_q) * IDX_W'(LANES);
   assign lane_w = snap_q[idx +: LANES];
   assign addr_w = ADDR_W'(pix_q) * ADDR_W'(BEATS) + ADDR_W'(beat_q);

   // outputs read as zero whenever no beat is being offered
   assign wr_addr_o = wr_en_o ? addr_w : '0;
   assign wr_data_o = wr_en_o ? lane_w : '0;

endmodule

// File: tb/tb_fire9_expand1_ofm_writer.sv
// Directed bench for fire9_expand1_ofm_writer: beat order, stalls,
// frame completion, overrun and mid-frame reset.
module tb_fire9_expand1_ofm_writer;

   localparam int DSP_NO = 368;
   localparam int WIDTH  = 16;
   localparam int WOUT   = 8;
   localparam int LANES  = 4;
   localparam int BEATS  = 92;
   localparam int ADDR_W = 13;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          sample_i;
   logic [DSP_NO-1:0][WIDTH-1:0]  ofm_i;
   logic                          wr_ready_i;
   logic                          wr_en_o;
   logic [ADDR_W-1:0]             wr_addr_o;
   logic [LANES*WIDTH-1:0]        wr_data_o;
   logic                          busy_o;
   logic                          ram_feedback_o;
   logic                          overrun_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fire9_expand1_ofm_writer #(
      .DSP_NO (DSP_NO),
      .WIDTH  (WIDTH),
      .WOUT   (WOUT),
      .LANES  (LANES)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sample_i       (sample_i),
      .ofm_i          (ofm_i),
      .wr_ready_i     (wr_ready_i),
      .wr_en_o        (wr_en_o),
      .wr_addr_o      (wr_addr_o),
      .wr_data_o      (wr_data_o),
      .busy_o         (busy_o),
      .ram_feedback_o (ram_feedback_o),
      .overrun_o      (overrun_o)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_beat(input int base, input int b);
      logic [63:0] e;
      e = '0;
      for (int k = 0; k < LANES; k++)
         e[k*WIDTH +: WIDTH] = WIDTH'(base + b*LANES + k);
      return e;
   endfunction

   task automatic set_ofm(input int base);
      for (int c = 0; c < DSP_NO; c++)
         ofm_i[c] = WIDTH'(base + c);
   endtask

   // Caller raises sample_i at a negedge, then calls this to consume beats.
   task automatic drain(input int pix, input int base, input bit stall,
                        input int ovr_at, input bit samp_last,
                        input int nbase, input int abort_beat);
      int beat;
      int cyc;
      bit rdy;
      beat = 0;
      cyc  = 0;
      while (beat < BEATS && cyc < 400) begin
         @(negedge clk);
         sample_i = 1'b0;
         rdy = stall ? (cyc % 2 == 1) : 1'b1;
         wr_ready_i = rdy;
         if (cyc == 0) begin
            check($sformatf("lat p%0d", pix), wr_en_o, 1'b1);
            check($sformatf("busy p%0d", pix), busy_o, 1'b1);
         end
         if (beat == abort_beat) begin
            rst = 1'b1;
            break;
         end
         if (cyc == ovr_at) begin
            sample_i = 1'b1;
            set_ofm(nbase);
         end
         if (wr_en_o) begin
            check($sformatf("addr p%0d b%0d", pix, beat), wr_addr_o,
                  pix*BEATS + beat);
            check($sformatf("data p%0d b%0d", pix, beat), wr_data_o,
                  exp_beat(base, beat));
            if (beat == 5 && base == 0)
               check("beat5", wr_data_o, 64'h0017_0016_0015_0014);
            if (rdy) begin
               if (samp_last && beat == BEATS-1) begin
                  sample_i = 1'b1;
                  set_ofm(nbase);
               end
               beat++;
            end
         end
         cyc++;
      end
      if (abort_beat < 0)
         check($sformatf("beats p%0d", pix), beat, BEATS);
      if (ovr_at >= 0)
         check("ovr_set", overrun_o, 1'b1);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " wr_en"}, wr_en_o, 1'b0);
      check({tag, " busy"}, busy_o, 1'b0);
      check({tag, " fb"}, ram_feedback_o, 1'b0);
      check({tag, " ovr"}, overrun_o, 1'b0);
      check({tag, " addr"}, wr_addr_o, '0);
      check({tag, " data"}, wr_data_o, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst        = 1'b1;
      sample_i   = 1'b0;
      wr_ready_i = 1'b1;
      set_ofm(0);
      repeat (3) @(negedge clk);
      check_idle_zero("rst");
      rst = 1'b0;

      // pixel 0, ready tied high
      @(negedge clk);
      set_ofm(0);
      sample_i = 1'b1;
      drain(0, 0, 1'b0, -1, 1'b0, 0, -1);
      @(negedge clk);
      check("busy_fall p0", busy_o, 1'b0);
      check("wr_en_fall p0", wr_en_o, 1'b0);

      // pixel 1, ready low every other cycle
      set_ofm(100);
      sample_i = 1'b1;
      drain(1, 100, 1'b1, -1, 1'b0, 0, -1);
      @(negedge clk);
      check("busy_fall p1", busy_o, 1'b0);

      // pixel 2 overrun at cycle 50, new sample on its final accept
      set_ofm(300);
      sample_i = 1'b1;
      drain(2, 300, 1'b0, 50, 1'b1, 600, -1);
      // pixel 3 follows with no idle gap, reset at beat 40
      drain(3, 600, 1'b0, -1, 1'b0, 0, 40);
      check("ovr_keep", overrun_o, 1'b1);
      @(negedge clk);
      check_idle_zero("abort");
      rst = 1'b0;
      set_ofm(900);
      sample_i = 1'b1;
      drain(0, 900, 1'b0, -1, 1'b0, 0, -1);
      @(negedge clk);
      check("ovr_clear", overrun_o, 1'b0);
      check("busy_fall re", busy_o, 1'b0);

      // full frame of 64 pixels
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < WOUT*WOUT; p++) begin
         @(negedge clk);
         set_ofm(p*3);
         sample_i = 1'b1;
         drain(p, p*3, 1'b0, -1, 1'b0, 0, -1);
         @(negedge clk);
         check($sformatf("fb p%0d", p), ram_feedback_o, p == WOUT*WOUT-1);
         check($sformatf("busy p%0d end", p), busy_o, 1'b0);
         if (p < WOUT*WOUT-1)
            repeat (18) @(negedge clk);
      end
      check("done wr_en", wr_en_o, 1'b0);
      @(negedge clk);
      check("fb one cycle", ram_feedback_o, 1'b0);

      // 65th sample is ignored
      set_ofm(5);
      sample_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         sample_i = 1'b0;
         if (wr_en_o || busy_o)
            seen++;
      end
      check("done no write", seen, 0);
      check("done no ovr", overrun_o, 1'b0);
      check("done fb low", ram_feedback_o, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
